// File: rtl/wb_unit_pkg.sv
// wb_unit_pkg: shared constants for the writeback stage.
//   Load funct3 encodings, the zero register index and the register
//   address/data widths used by wb_unit and load_extract.
package wb_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;
    localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/wb_unit_load_extract.sv
// load_extract: combinational byte/half/word extraction of a load response.
//   raw    in  XLEN  aligned memory word
//   off    in  2     byte offset addr[1:0]
//   funct3 in  3     load type
//   data   out XLEN  extended load value
//   err    out 1     unsupported funct3 or misaligned half/word
module load_extract
    import wb_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[{off, 3'b000} +: 8];
        half_sel = raw[{off[1], 4'b0000} +: 16];
        data     = '0;
        err      = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data = {{(XLEN-16){half_sel[15]}}, half_sel};
                err  = off[0];
            end
            F3_LHU: begin
                data = {{(XLEN-16){1'b0}}, half_sel};
                err  = off[0];
            end
            F3_LW: begin
                data = raw;
                err  = (off != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback stage, sole driver of the register file write port.
//   Merges EX results (alu_*) and LSU load responses (lsu_*), LSU first.
//   Tracks a pending-load busy mask and an outstanding-load count.
//   clk, rst (async, active-high)
//   alu_valid/alu_ready/alu_we/alu_rd/alu_data/alu_pc   EX result channel
//   ld_issue_valid/ld_issue_ready/ld_issue_rd           load issue tracking
//   lsu_valid/lsu_rd/lsu_raw/lsu_off/lsu_funct3/lsu_pc  load response
//   busy_mask                                           pending-load registers
//   rd_we/rd_waddr/rd_wdata                             regfile write port (registered)
//   lsu_err                                             one-cycle bad-load pulse
// Optional build macro WB_COMMIT_EN adds commit_valid/commit_pc and a 64-bit
// retired-instruction counter (commit_count) for difftest.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int NREG            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic                    alu_we,
    input  logic [$clog2(NREG)-1:0] alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    input  logic [31:0]             alu_pc,
    input  logic                    ld_issue_valid,
    output logic                    ld_issue_ready,
    input  logic [$clog2(NREG)-1:0] ld_issue_rd,
    input  logic                    lsu_valid,
    input  logic [$clog2(NREG)-1:0] lsu_rd,
    input  logic [XLEN-1:0]         lsu_raw,
    input  logic [1:0]              lsu_off,
    input  logic [2:0]              lsu_funct3,
    input  logic [31:0]             lsu_pc,
    output logic [NREG-1:0]         busy_mask,
    output logic                    rd_we,
    output logic [$clog2(NREG)-1:0] rd_waddr,
    output logic [XLEN-1:0]         rd_wdata,
`ifdef WB_COMMIT_EN
    output logic                    commit_valid,
    output logic [31:0]             commit_pc,
    output logic [63:0]             commit_count,
`endif
    output logic                    lsu_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int RA_W  = $clog2(NREG);

    logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
    logic [NREG-1:0]  busy_nxt;
    logic             alu_accept, ld_issue;
    logic [XLEN-1:0]  ld_data;
    logic             ld_err;
    logic             wr_en;
    logic [RA_W-1:0]  wr_addr;
    logic [XLEN-1:0]  wr_data;

    load_extract #(.XLEN(XLEN)) u_extract (
        .raw    (lsu_raw),
        .off    (lsu_off),
        .funct3 (lsu_funct3),
        .data   (ld_data),
        .err    (ld_err)
    );

    // LSU responses cannot be back-pressured, so they always win the port.
    assign alu_ready      = !lsu_valid;
    assign alu_accept     = alu_valid && !lsu_valid;
    // A same-cycle response frees a slot, so an issue may proceed at the limit.
    assign ld_issue_ready = (out_cnt < CNT_W'(MAX_OUTSTANDING)) || lsu_valid;
    assign ld_issue       = ld_issue_valid && ld_issue_ready;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rd_waddr;
        wr_data = rd_wdata;
        if (lsu_valid) begin
            wr_en   = (lsu_rd != RA_W'(ZERO_REG)) && !ld_err;
            wr_addr = lsu_rd;
            wr_data = ld_data;
        end else if (alu_accept) begin
            wr_en   = alu_we && (alu_rd != RA_W'(ZERO_REG));
            wr_addr = alu_rd;
            wr_data = alu_data;
        end
    end

    // Clear first, then set, so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_nxt = busy_mask;
        if (lsu_valid)
            busy_nxt[lsu_rd] = 1'b0;
        if (ld_issue)
            busy_nxt[ld_issue_rd] = 1'b1;
        busy_nxt[ZERO_REG] = 1'b0;
    end

    // A response with nothing outstanding saturates at zero instead of wrapping.
    always_comb begin
        out_cnt_nxt = out_cnt;
        case ({ld_issue, lsu_valid})
            2'b10: out_cnt_nxt = out_cnt + 1'b1;
            2'b01: out_cnt_nxt = (out_cnt == '0) ? '0 : out_cnt - 1'b1;
            default: out_cnt_nxt = out_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_we     <= 1'b0;
            rd_waddr  <= '0;
            rd_wdata  <= '0;
            lsu_err   <= 1'b0;
            busy_mask <= '0;
            out_cnt   <= '0;
        end else begin
            rd_we     <= wr_en;
            lsu_err   <= lsu_valid && ld_err;
            busy_mask <= busy_nxt;
            out_cnt   <= out_cnt_nxt;
            if (wr_en) begin
                rd_waddr <= wr_addr;
                rd_wdata <= wr_data;
            end
        end
    end

`ifdef WB_COMMIT_EN
    logic accept;
    assign accept = lsu_valid || alu_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_count <= '0;
        end else begin
            commit_valid <= accept;
            if (accept) begin
                commit_pc    <= lsu_valid ? lsu_pc : alu_pc;
                commit_count <= commit_count + 64'd1;
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{alu_pc, lsu_pc};
`endif

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data, alu_pc;
    logic        ld_issue_valid, ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_raw;
    logic [1:0]  lsu_off;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_pc;
    logic [31:0] busy_mask;
    logic        rd_we;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        lsu_err;
`ifdef WB_COMMIT_EN
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [63:0] commit_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_we         (alu_we),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .alu_pc         (alu_pc),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_ready (ld_issue_ready),
        .ld_issue_rd    (ld_issue_rd),
        .lsu_valid      (lsu_valid),
        .lsu_rd         (lsu_rd),
        .lsu_raw        (lsu_raw),
        .lsu_off        (lsu_off),
        .lsu_funct3     (lsu_funct3),
        .lsu_pc         (lsu_pc),
        .busy_mask      (busy_mask),
        .rd_we          (rd_we),
        .rd_waddr       (rd_waddr),
        .rd_wdata       (rd_wdata),
`ifdef WB_COMMIT_EN
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_count   (commit_count),
`endif
        .lsu_err        (lsu_err)
    );

    typedef struct {
        logic        is_lsu;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [1:0]  off;
        logic [2:0]  f3;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic is_lsu, logic we, logic [4:0] rd, logic [31:0] val,
                                logic [1:0] off, logic [2:0] f3, logic exp_we,
                                logic [31:0] exp_data, logic exp_err);
        vec_t v;
        v.is_lsu = is_lsu; v.we = we; v.rd = rd; v.val = val; v.off = off; v.f3 = f3;
        v.exp_we = exp_we; v.exp_addr = rd; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_we = 0; alu_rd = 0; alu_data = 0; alu_pc = 0;
        ld_issue_valid = 0; ld_issue_rd = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_raw = 0; lsu_off = 0; lsu_funct3 = 0; lsu_pc = 0;
    endtask

    task automatic lsu_resp(input logic [4:0] rd, input logic [31:0] raw,
                            input logic [1:0] off, input logic [2:0] f3);
        lsu_valid = 1; lsu_rd = rd; lsu_raw = raw; lsu_off = off; lsu_funct3 = f3;
        lsu_pc = 32'h8000_0100;
    endtask

    localparam logic [31:0] RAW = 32'h80FF7F01;

    initial begin
        vecs[0]  = mk(0, 1, 5'd5,  32'h0000_1234, 2'd0, 3'b000, 1, 32'h0000_1234, 0);
        vecs[1]  = mk(1, 0, 5'd1,  RAW, 2'd3, 3'b000, 1, 32'hFFFF_FF80, 0);
        vecs[2]  = mk(1, 0, 5'd2,  RAW, 2'd1, 3'b100, 1, 32'h0000_007F, 0);
        vecs[3]  = mk(1, 0, 5'd3,  RAW, 2'd2, 3'b001, 1, 32'hFFFF_80FF, 0);
        vecs[4]  = mk(1, 0, 5'd4,  RAW, 2'd0, 3'b101, 1, 32'h0000_7F01, 0);
        vecs[5]  = mk(1, 0, 5'd6,  RAW, 2'd0, 3'b010, 1, 32'h80FF_7F01, 0);
        vecs[6]  = mk(1, 0, 5'd8,  RAW, 2'd2, 3'b100, 1, 32'h0000_00FF, 0);
        vecs[7]  = mk(1, 0, 5'd9,  RAW, 2'd0, 3'b000, 1, 32'h0000_0001, 0);
        vecs[8]  = mk(1, 0, 5'd10, RAW, 2'd2, 3'b101, 1, 32'h0000_80FF, 0);
        vecs[9]  = mk(1, 0, 5'd11, RAW, 2'd2, 3'b010, 0, 32'h0, 1);
        vecs[10] = mk(1, 0, 5'd12, RAW, 2'd0, 3'b011, 0, 32'h0, 1);
        vecs[11] = mk(1, 0, 5'd13, RAW, 2'd1, 3'b001, 0, 32'h0, 1);
        vecs[12] = mk(0, 0, 5'd14, 32'hDEAD_BEEF, 2'd0, 3'b000, 0, 32'h0, 0);
        vecs[13] = mk(0, 1, 5'd0,  32'hDEAD_BEEF, 2'd0, 3'b000, 0, 32'h0, 0);
        vecs[14] = mk(1, 0, 5'd0,  RAW, 2'd0, 3'b010, 0, 32'h0, 0);

        idle_inputs();
        rst = 1;
        #12;
        chk("reset_rd_we", rd_we, 0);
        chk("reset_waddr", rd_waddr, 0);
        chk("reset_wdata", rd_wdata, 0);
        chk("reset_busy", busy_mask, 0);
        chk("reset_err", lsu_err, 0);
        @(negedge clk);
        rst = 0;
        step();

        for (int i = 0; i < 15; i++) begin
            idle_inputs();
            if (vecs[i].is_lsu) lsu_resp(vecs[i].rd, vecs[i].val, vecs[i].off, vecs[i].f3);
            else begin
                alu_valid = 1; alu_we = vecs[i].we; alu_rd = vecs[i].rd;
                alu_data = vecs[i].val; alu_pc = 32'h8000_0000 + 32'(i * 4);
            end
            #1;
            chk($sformatf("v%0d_alu_ready", i), alu_ready, !vecs[i].is_lsu);
            step();
            chk($sformatf("v%0d_rd_we", i), rd_we, vecs[i].exp_we);
            chk($sformatf("v%0d_lsu_err", i), lsu_err, vecs[i].exp_err);
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_waddr", i), rd_waddr, vecs[i].exp_addr);
                chk($sformatf("v%0d_wdata", i), rd_wdata, vecs[i].exp_data);
            end
        end
        // count was driven to zero by unmatched responses; it must not have wrapped
        idle_inputs();
        #1;
        chk("saturate_ready", ld_issue_ready, 1);
        chk("x0_load_busy", busy_mask, 0);

        // hold: rd_* keep last write when idle
        alu_valid = 1; alu_we = 1; alu_rd = 5'd9; alu_data = 32'hAA;
        step();
        idle_inputs();
        step();
        chk("hold_rd_we", rd_we, 0);
        chk("hold_waddr", rd_waddr, 5'd9);
        chk("hold_wdata", rd_wdata, 32'hAA);

        // conflict: LSU first, ALU held and written next cycle
        alu_valid = 1; alu_we = 1; alu_rd = 5'd20; alu_data = 32'h55;
        lsu_resp(5'd21, 32'h77, 2'd0, 3'b010);
        #1;
        chk("conflict_alu_ready", alu_ready, 0);
        step();
        chk("conflict_lsu_waddr", rd_waddr, 5'd21);
        chk("conflict_lsu_wdata", rd_wdata, 32'h77);
        lsu_valid = 0;
        #1;
        chk("conflict_alu_ready_after", alu_ready, 1);
        step();
        chk("conflict_alu_we", rd_we, 1);
        chk("conflict_alu_waddr", rd_waddr, 5'd20);
        chk("conflict_alu_wdata", rd_wdata, 32'h55);
        idle_inputs();

        // scoreboard: rd7 x3, rd12 x1 -> full
        for (int i = 0; i < 4; i++) begin
            ld_issue_valid = 1; ld_issue_rd = (i == 3) ? 5'd12 : 5'd7;
            step();
        end
        idle_inputs();
        #1;
        chk("full_ready", ld_issue_ready, 0);
        chk("full_busy", busy_mask, (32'd1 << 7) | (32'd1 << 12));
        lsu_resp(5'd7, 32'h1, 2'd0, 3'b010);
        ld_issue_valid = 1; ld_issue_rd = 5'd7;
        #1;
        chk("same_cycle_ready", ld_issue_ready, 1);
        step();
        idle_inputs();
        #1;
        chk("same_cycle_busy", busy_mask, (32'd1 << 7) | (32'd1 << 12));
        chk("same_cycle_count", ld_issue_ready, 0);
        lsu_resp(5'd7, 32'h1, 2'd0, 3'b010);
        step();
        idle_inputs();
        chk("resp7_busy", busy_mask, 32'd1 << 12);
        lsu_resp(5'd12, RAW, 2'd2, 3'b010);
        step();
        idle_inputs();
        chk("err_rd_we", rd_we, 0);
        chk("err_pulse", lsu_err, 1);
        chk("err_busy_clear", busy_mask, 0);
        ld_issue_valid = 1; ld_issue_rd = 5'd0;
        step();
        chk("err_pulse_end", lsu_err, 0);
        chk("issue_x0_busy", busy_mask, 0);
        chk("err_count_dec", ld_issue_ready, 1);

        // final slot with a live write, then async reset mid-stream
        ld_issue_valid = 1; ld_issue_rd = 5'd9;
        alu_valid = 1; alu_we = 1; alu_rd = 5'd5; alu_data = 32'h1234;
        step();
        idle_inputs();
        chk("pre_rst_ready", ld_issue_ready, 0);
        chk("pre_rst_busy", busy_mask, 32'd1 << 9);
        chk("pre_rst_we", rd_we, 1);
        #1;
        rst = 1;
        #1;
        chk("rst_rd_we", rd_we, 0);
        chk("rst_waddr", rd_waddr, 0);
        chk("rst_wdata", rd_wdata, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_err", lsu_err, 0);
        chk("rst_count", ld_issue_ready, 1);
        @(negedge clk);
        rst = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
